// File: rtl/loop_counter_bank.sv
// Bank of N loop counters with per-channel limits; flags z (comb) and done (registered edge pulse).
// Latency: strobes update count/limit at the next edge; no backpressure. Define CNT_SAT_EN for saturating step plus sticky sat.
module loop_counter_bank #(
    parameter int          W    = 8,
    parameter int          N    = 4,
    parameter int          SELW = 2,
    parameter int unsigned STEP = 1
) (
    input  logic            Clk,
    input  logic            RST,
    input  logic [W-1:0]    BusOut,
    input  logic            Wen,
    input  logic            LWen,
    input  logic [SELW-1:0] WSel,
    input  logic            Clr,
    input  logic            INC,
    input  logic            DEC,
    input  logic [SELW-1:0] OSel,
    input  logic [SELW-1:0] RSel,
    output logic [W-1:0]    dout,
    output logic [W-1:0]    lout,
    output logic [N-1:0]    z,
    output logic [N-1:0]    done
`ifdef CNT_SAT_EN
    ,
    output logic [N-1:0]    sat
`endif
);

    localparam logic [W-1:0] STEP_W = W'(STEP);

    logic [W-1:0] cnt_q [N];
    logic [W-1:0] cnt_d [N];
    logic [W-1:0] lim_q [N];
    logic [W-1:0] lim_d [N];
    logic [N-1:0] z_d;
    logic [N-1:0] done_q;
    logic [N-1:0] done_d;
`ifdef CNT_SAT_EN
    logic [N-1:0] sat_q;
    logic [N-1:0] sat_d;
    logic [W:0]   inc_sum;
`endif

    // Selects beyond N-1 never match any channel, so they are silently ignored.
    always_comb begin
`ifdef CNT_SAT_EN
        sat_d   = sat_q;
        inc_sum = '0;
`endif
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            lim_d[i] = lim_q[i];
            if (LWen && WSel == SELW'(i)) begin
                lim_d[i] = BusOut;
            end
            if (Wen && WSel == SELW'(i)) begin
                cnt_d[i] = BusOut;
`ifdef CNT_SAT_EN
                sat_d[i] = 1'b0;
`endif
            end else if (Clr && OSel == SELW'(i)) begin
                cnt_d[i] = '0;
`ifdef CNT_SAT_EN
                sat_d[i] = 1'b0;
`endif
            end else if ((INC ^ DEC) && OSel == SELW'(i)) begin
`ifdef CNT_SAT_EN
                if (INC) begin
                    inc_sum = {1'b0, cnt_q[i]} + {1'b0, STEP_W};
                    if (inc_sum[W]) begin
                        cnt_d[i] = '1;
                        sat_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = inc_sum[W-1:0];
                    end
                end else if (cnt_q[i] < STEP_W) begin
                    cnt_d[i] = '0;
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - STEP_W;
                end
`else
                cnt_d[i] = INC ? (cnt_q[i] + STEP_W) : (cnt_q[i] - STEP_W);
`endif
            end
            z_d[i] = (lim_d[i] <= cnt_d[i]);
        end
        done_d = z_d & ~z;
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
                lim_q[i] <= '0;
            end
            done_q <= '0;
`ifdef CNT_SAT_EN
            sat_q  <= '0;
`endif
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
                lim_q[i] <= lim_d[i];
            end
            done_q <= done_d;
`ifdef CNT_SAT_EN
            sat_q  <= sat_d;
`endif
        end
    end

    always_comb begin
        dout = '0;
        lout = '0;
        for (int i = 0; i < N; i++) begin
            z[i] = (lim_q[i] <= cnt_q[i]);
            if (RSel == SELW'(i)) begin
                dout = cnt_q[i];
                lout = lim_q[i];
            end
        end
    end

    assign done = done_q;
`ifdef CNT_SAT_EN
    assign sat = sat_q;
`endif

endmodule

// File: tb/tb_loop_counter_bank.sv
// Scoreboard bench: u_a is the default bank, u_b a 3-channel STEP=3 bank exercising out-of-range selects.
module tb_loop_counter_bank;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       RST, tgt, Wen, LWen, Clr, INC, DEC;
    logic [1:0] WSel, OSel, RSel;
    logic [7:0] BusOut;
    logic [7:0] a_dout, a_lout, b_dout, b_lout;
    logic [3:0] a_z, a_done;
    logic [2:0] b_z, b_done;
`ifdef CNT_SAT_EN
    logic [3:0] a_sat;
    logic [2:0] b_sat;
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [4:0] NOP = 5'b00000, WR = 5'b10000, LW = 5'b01000,
                           CL  = 5'b00100, IN = 5'b00010, DE = 5'b00001;

    loop_counter_bank #(.W(8), .N(4), .SELW(2), .STEP(1)) u_a (
        .Clk(Clk), .RST(RST), .BusOut(BusOut),
        .Wen(Wen & ~tgt), .LWen(LWen & ~tgt), .WSel(WSel),
        .Clr(Clr & ~tgt), .INC(INC & ~tgt), .DEC(DEC & ~tgt), .OSel(OSel),
        .RSel(RSel), .dout(a_dout), .lout(a_lout), .z(a_z), .done(a_done)
`ifdef CNT_SAT_EN
        , .sat(a_sat)
`endif
    );

    loop_counter_bank #(.W(8), .N(3), .SELW(2), .STEP(3)) u_b (
        .Clk(Clk), .RST(RST), .BusOut(BusOut),
        .Wen(Wen & tgt), .LWen(LWen & tgt), .WSel(WSel),
        .Clr(Clr & tgt), .INC(INC & tgt), .DEC(DEC & tgt), .OSel(OSel),
        .RSel(RSel), .dout(b_dout), .lout(b_lout), .z(b_z), .done(b_done)
`ifdef CNT_SAT_EN
        , .sat(b_sat)
`endif
    );

    typedef struct {
        string      nm;
        bit         u;
        logic [7:0] d;
        logic [7:0] l;
        logic [3:0] z;
        logic [3:0] dn;
        bit         cs;
        bit         s;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input string f, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s got %h expected %h", nm, f, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what must be visible after the edge.
    task automatic cyc(input string nm, input bit u, input bit rst, input logic [4:0] op,
                       input logic [1:0] ws, input logic [1:0] os, input logic [1:0] rs,
                       input logic [7:0] bus, input logic [7:0] ed, input logic [7:0] el,
                       input logic [3:0] ez, input logic [3:0] edn,
                       input bit cs = 1'b0, input bit s = 1'b0);
        exp_t e;
        tgt = u; RST = rst;
        {Wen, LWen, Clr, INC, DEC} = op;
        WSel = ws; OSel = os; RSel = rs; BusOut = bus;
        e.nm = nm; e.u = u; e.d = ed; e.l = el; e.z = ez; e.dn = edn; e.cs = cs; e.s = s;
        sb.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    always @(posedge Clk) begin
        #1;
        if (sb.size() != 0) begin
            m = sb.pop_front();
            if (!m.u) begin
                chk(m.nm, "dout", a_dout, m.d);
                chk(m.nm, "lout", a_lout, m.l);
                chk(m.nm, "z",    {4'h0, a_z},    {4'h0, m.z});
                chk(m.nm, "done", {4'h0, a_done}, {4'h0, m.dn});
`ifdef CNT_SAT_EN
                if (m.cs) chk(m.nm, "sat0", {7'd0, a_sat[0]}, {7'd0, m.s});
`endif
            end else begin
                chk(m.nm, "dout", b_dout, m.d);
                chk(m.nm, "lout", b_lout, m.l);
                chk(m.nm, "z",    {5'h0, b_z},    {4'h0, m.z});
                chk(m.nm, "done", {5'h0, b_done}, {4'h0, m.dn});
            end
        end
    end

    initial begin
        RST = 1'b1; tgt = 1'b0; {Wen, LWen, Clr, INC, DEC} = NOP;
        WSel = 0; OSel = 0; RSel = 0; BusOut = 0;
        repeat (2) @(negedge Clk);

        // reset, then writes, then reset overriding a write
        cyc("rst_hold",  0, 1, NOP, 0, 0, 0, 8'h00, 8'h00, 8'h00, 4'hF, 4'h0);
        cyc("wr0",       0, 0, WR,  0, 0, 0, 8'h12, 8'h12, 8'h00, 4'hF, 4'h0);
        cyc("lim2",      0, 0, LW,  2, 0, 2, 8'h40, 8'h00, 8'h40, 4'hB, 4'h0);
        cyc("wr3",       0, 0, WR,  3, 0, 3, 8'h33, 8'h33, 8'h00, 4'hB, 4'h0);
        cyc("rst_ovr",   0, 1, WR,  1, 0, 2, 8'h77, 8'h00, 8'h00, 4'hF, 4'h0);
        cyc("post_rst",  0, 0, NOP, 0, 0, 2, 8'h00, 8'h00, 8'h00, 4'hF, 4'h0);
        cyc("post_rst3", 0, 0, NOP, 0, 0, 3, 8'h00, 8'h00, 8'h00, 4'hF, 4'h0);

        // count up to limit on ch1
        cyc("lim1",      0, 0, LW,  1, 0, 1, 8'h05, 8'h00, 8'h05, 4'hD, 4'h0);
        for (int k = 1; k <= 5; k++)
            cyc("inc1", 0, 0, IN, 0, 1, 1, 8'h00, 8'(k), 8'h05,
                (k == 5) ? 4'hF : 4'hD, (k == 5) ? 4'h2 : 4'h0);
        cyc("hold1",     0, 0, NOP, 0, 0, 1, 8'h00, 8'h05, 8'h05, 4'hF, 4'h0);
        cyc("inc1_6",    0, 0, IN,  0, 1, 1, 8'h00, 8'h06, 8'h05, 4'hF, 4'h0);

        // priority on ch2
        cyc("wr2",       0, 0, WR,      2, 0, 2, 8'h07, 8'h07, 8'h00, 4'hF, 4'h0);
        cyc("prio",      0, 0, WR|CL|IN, 2, 2, 2, 8'h03, 8'h03, 8'h00, 4'hF, 4'h0);
        cyc("incdec",    0, 0, IN|DE,   0, 2, 2, 8'h00, 8'h03, 8'h00, 4'hF, 4'h0);
        cyc("clr_inc",   0, 0, CL|IN,   0, 2, 2, 8'h00, 8'h00, 8'h00, 4'hF, 4'h0);
        cyc("dec_wrap2", 0, 0, DE,      0, 2, 2, 8'h00, SAT ? 8'h00 : 8'hFF, 8'h00, 4'hF, 4'h0);

        // concurrency
        cyc("wr3b",      0, 0, WR,    3, 0, 3, 8'h04, 8'h04, 8'h00, 4'hF, 4'h0);
        cyc("conc",      0, 0, WR|IN, 0, 3, 3, 8'h09, 8'h05, 8'h00, 4'hF, 4'h0);
        cyc("conc_rd0",  0, 0, NOP,   0, 0, 0, 8'h00, 8'h09, 8'h00, 4'hF, 4'h0);
        cyc("lim1_hi",   0, 0, LW,    1, 0, 1, 8'hA0, 8'h06, 8'hA0, 4'hD, 4'h0);
        cyc("wr_lw1",    0, 0, WR|LW, 1, 0, 1, 8'h06, 8'h06, 8'h06, 4'hF, 4'h2);
        cyc("hold1b",    0, 0, NOP,   0, 0, 1, 8'h00, 8'h06, 8'h06, 4'hF, 4'h0);
        cyc("lim1_7",    0, 0, LW,    1, 0, 1, 8'h07, 8'h06, 8'h07, 4'hD, 4'h0);
        cyc("lim1_6",    0, 0, LW,    1, 0, 1, 8'h06, 8'h06, 8'h06, 4'hF, 4'h2);

        // wrap (or saturate) on ch0
        cyc("wr0_ff",    0, 0, WR, 0, 0, 0, 8'hFF, 8'hFF, 8'h00, 4'hF, 4'h0);
        cyc("inc_wrap0", 0, 0, IN, 0, 0, 0, 8'h00, SAT ? 8'hFF : 8'h00, 8'h00, 4'hF, 4'h0, 1'b1, SAT);
        cyc("dec_wrap0", 0, 0, DE, 0, 0, 0, 8'h00, SAT ? 8'hFE : 8'hFF, 8'h00, 4'hF, 4'h0, 1'b1, SAT);
        cyc("clr0",      0, 0, CL, 0, 0, 0, 8'h00, 8'h00, 8'h00, 4'hF, 4'h0, 1'b1, 1'b0);
        cyc("dec0",      0, 0, DE, 0, 0, 0, 8'h00, SAT ? 8'h00 : 8'hFF, 8'h00, 4'hF, 4'h0);

        // STEP=3, N=3 bank: step, limit pulse, out-of-range selects, wrap
        cyc("b_wr0",     1, 0, WR,    0, 0, 0, 8'h0A, 8'h0A, 8'h00, 4'h7, 4'h0);
        cyc("b_dec",     1, 0, DE,    0, 0, 0, 8'h00, 8'h07, 8'h00, 4'h7, 4'h0);
        cyc("b_lim",     1, 0, LW,    0, 0, 0, 8'h08, 8'h07, 8'h08, 4'h6, 4'h0);
        cyc("b_inc",     1, 0, IN,    0, 0, 0, 8'h00, 8'h0A, 8'h08, 4'h7, 4'h1);
        cyc("b_hold",    1, 0, NOP,   0, 0, 0, 8'h00, 8'h0A, 8'h08, 4'h7, 4'h0);
        cyc("b_oor_wr",  1, 0, WR|LW, 3, 0, 3, 8'h55, 8'h00, 8'h00, 4'h7, 4'h0);
        cyc("b_oor_clr", 1, 0, CL,    0, 3, 0, 8'h00, 8'h0A, 8'h08, 4'h7, 4'h0);
        cyc("b_oor_inc", 1, 0, IN,    0, 3, 1, 8'h00, 8'h00, 8'h00, 4'h7, 4'h0);
        cyc("b_wr1",     1, 0, WR,    1, 0, 1, 8'hFE, 8'hFE, 8'h00, 4'h7, 4'h0);
        cyc("b_wrap",    1, 0, IN,    0, 1, 1, 8'h00, SAT ? 8'hFF : 8'h01, 8'h00, 4'h7, 4'h0);

        {Wen, LWen, Clr, INC, DEC} = NOP;
        repeat (2) @(negedge Clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/loop_counter_bank.md
Name: loop_counter_bank

Overview:
- Parametrised successor to the single loop-index register used by the processor's loop instructions.
- Holds N independent W-bit loop counters, each paired with its own W-bit limit register.
- Counters support bus write, clear, increment and decrement. Each channel has a per-channel "limit reached" flag and a one-cycle rising-edge pulse.
- Sits on the datapath bus next to the general registers. The control unit drives the write, clear and increment/decrement strobes.

Parameters:
W, 8, counter/limit/bus width in bits.
N, 4, number of counter channels (N >= 2).
SELW, 2, channel-select width; must satisfy 2^SELW >= N.
STEP, 1, increment/decrement amount; W-bit unsigned, STEP >= 1.

Ports:
Clk  in  1  clock; all state updates on rising edge.
RST  in  1  synchronous active-high reset.
BusOut  in  W  datapath bus value to load.
Wen  in  1  load BusOut into count[WSel].
LWen  in  1  load BusOut into lim[WSel].
WSel  in  SELW  write channel select.
Clr  in  1  clear count[OSel] to 0.
INC  in  1  add STEP to count[OSel].
DEC  in  1  subtract STEP from count[OSel].
OSel  in  SELW  operation channel select.
RSel  in  SELW  read channel select.
dout  out  W  count[RSel]; combinational mux of registered counts.
lout  out  W  lim[RSel]; combinational mux.
z  out  N  z[i] = (lim[i] <= count[i]), unsigned compare; combinational from registers.
done  out  N  registered one-cycle pulse when z[i] goes 0 -> 1.

Behaviour:
- Reset: RST high at a rising edge clears all count[i], all lim[i] and all done[i] to 0.
  - z therefore reads all-ones after reset.
  - RST overrides every other input in that cycle.
- Per-channel priority for count[i] (highest first):
  - RST.
  - Wen with WSel==i: load BusOut.
  - Clr with OSel==i: load 0.
  - INC xor DEC with OSel==i: step.
  - Otherwise hold.
- INC and DEC asserted together: no change to the count.
- Wen and an operation targeting different channels in the same cycle: both take effect.
- LWen is independent of the count path. Limit and count of the same channel may be written in the same cycle; both load BusOut.
- Selects >= N (when 2^SELW > N):
  - Writes and operations are ignored.
  - dout and lout read 0.
- Arithmetic: count +/- STEP modulo 2^W (wrap). Examples: 255+1 -> 0; 0-1 -> 255 for W=8.
- Flag timing:
  - Update latency is 1 cycle: a strobe at edge k changes count, and therefore z, after edge k.
  - done[i] is computed as next_z[i] & ~z[i] and registered. It is high for exactly the cycle after edge k, then clears unless z rises again.
  - No done pulse is generated on the reset edge or on the cycle following reset.
- Limit write: a limit write that makes z[i] rise also pulses done[i].
- Out-of-range selects: none of the above can affect any valid channel.

Optional Feature:
- Macro CNT_SAT_EN.
- Defined: increment and decrement saturate instead of wrapping.
  - count + STEP > 2^W-1 yields 2^W-1.
  - count < STEP on decrement yields 0.
  - Adds output port sat, N bits: sticky per channel, set when a saturation occurred. Cleared by RST, or by Wen/Clr on that channel.
- Not defined: modulo wrap as above, and the sat port does not exist.

Test Plan:
- Reset: assert RST one cycle after arbitrary writes -> all dout=0, lout=0, z=4'b1111, done=0 for two cycles.
- Count to limit: LWen 5 on ch1, then INC ch1 for 5 cycles -> dout(RSel=1) goes 1..5. z[1]=0 until count=5, then 1; done[1] pulses high exactly one cycle after the 5th INC edge.
- Priority: count2=7, then same cycle Wen ch2 BusOut=3, Clr ch2, INC ch2 -> count2=3. Next cycle INC and DEC together on ch2 -> count2 stays 3.
- Concurrency: Wen ch0 BusOut=9 and INC ch3 (count3=4) same cycle -> count0=9, count3=5. LWen and Wen ch1 with BusOut=6 same cycle -> count1=6, lim1=6, z[1]=1, done[1] pulses.
- Wrap: count0=255, INC -> 0; DEC -> 255. With CNT_SAT_EN: INC at 255 stays 255 and sat[0]=1; Clr ch0 -> sat[0]=0.
- STEP=3 build: count=10, DEC ch0 -> 7. Limit 8 on ch0 at count 7, INC -> 10, z[0]=1, done pulse once.
